// File: rtl/seg7_bus_monitor.sv
// Reads back a multiplexed 7-segment display bus: synchronises anode/segment lines,
// waits for a stable (digit, pattern) pair and shadows the decoded digit per position.
module seg7_bus_monitor #(
  parameter int unsigned NUM_DIGITS       = 8,
  parameter int unsigned STABLE_CYCLES    = 4,
  parameter bit          ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_DIGITS-1:0]     an_in,
  input  logic [0:6]                seg_in,
  output logic [4*NUM_DIGITS-1:0]   digit_code,
  output logic [NUM_DIGITS-1:0]     digit_valid,
  output logic [NUM_DIGITS-1:0]     digit_bad,
  output logic                      frame_done,
  output logic                      err_multi_anode
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  // Raw anode level meaning "nothing selected"
  localparam logic [NUM_DIGITS-1:0] AnIdle = {NUM_DIGITS{ANODE_ACTIVE_LOW}};

  typedef enum logic [1:0] {StIdle, StDwell, StHeld} state_e;

  // Returns {bad, code}; patterns are abcdefg, active-low
  function automatic logic [4:0] decode(input logic [0:6] p);
    case (p)
      7'b0000001: decode = 5'h00;
      7'b1001111: decode = 5'h01;
      7'b0010010: decode = 5'h02;
      7'b0000110: decode = 5'h03;
      7'b1001100: decode = 5'h04;
      7'b0100100: decode = 5'h05;
      7'b0100000: decode = 5'h06;
      7'b0001111: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0000100: decode = 5'h09;
      7'b1111110: decode = 5'h0A;
      7'b1111111: decode = 5'h0F;
      default:    decode = 5'h1E;
    endcase
  endfunction

  logic [NUM_DIGITS-1:0]   an_s1_q, an_s2_q;
  logic [0:6]              seg_s1_q, seg_s2_q;
  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [0:6]              pat_q, pat_d;
  logic                    commit_q, commit_d;
  logic [4*NUM_DIGITS-1:0] code_q, code_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   bad_q, bad_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic                    frame_q, frame_d;
  logic                    err_q, err_d;

  logic [NUM_DIGITS-1:0]   an_norm;
  logic [3:0]              n_active;
  logic [IdxW-1:0]         sel_idx;
  logic                    sel_valid, multi, same;
  logic [NUM_DIGITS-1:0]   commit_bit;
  logic [4:0]              dec;

  // Normalise anodes to active-high and find the single selected digit
  always_comb begin
    an_norm  = ANODE_ACTIVE_LOW ? ~an_s2_q : an_s2_q;
    n_active = 4'd0;
    sel_idx  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_norm[i]) begin
        n_active = n_active + 4'd1;
        sel_idx  = IdxW'(i);
      end
    end
    sel_valid = (n_active == 4'd1);
    multi     = (n_active > 4'd1);
  end

  // Stability FSM: count identical samples, flag a single commit per dwell
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    pat_d    = pat_q;
    commit_d = 1'b0;
    same     = (sel_idx == idx_q) && (seg_s2_q == pat_q);
    if (!sel_valid) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (state_q == StIdle || !same) begin
      idx_d = sel_idx;
      pat_d = seg_s2_q;
      cnt_d = CntW'(1);
      if (STABLE_CYCLES == 1) begin
        state_d  = StHeld;
        commit_d = 1'b1;
      end else begin
        state_d = StDwell;
      end
    end else if (state_q == StDwell) begin
      cnt_d = cnt_q + CntW'(1);
      if (cnt_d == CntW'(STABLE_CYCLES)) begin
        state_d  = StHeld;
        commit_d = 1'b1;
      end
    end
  end

  // Apply a flagged commit (idx_q/pat_q still hold the committed pair) and track the frame
  always_comb begin
    code_d     = code_q;
    valid_d    = valid_q;
    bad_d      = bad_q;
    err_d      = err_q | multi;
    commit_bit = '0;
    dec        = decode(pat_q);
    if (commit_q) begin
      code_d[4*idx_q +: 4] = dec[3:0];
      valid_d[idx_q]       = 1'b1;
      bad_d[idx_q]         = dec[4];
      commit_bit[idx_q]    = 1'b1;
    end
    // A commit landing on the clear edge seeds the next frame
    if (&mask_q) begin
      frame_d = 1'b1;
      mask_d  = commit_bit;
    end else begin
      frame_d = 1'b0;
      mask_d  = mask_q | commit_bit;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      an_s1_q  <= AnIdle;
      an_s2_q  <= AnIdle;
      seg_s1_q <= 7'b1111111;
      seg_s2_q <= 7'b1111111;
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      pat_q    <= 7'b1111111;
      commit_q <= 1'b0;
      code_q   <= '1;
      valid_q  <= '0;
      bad_q    <= '0;
      mask_q   <= '0;
      frame_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      an_s1_q  <= an_in;
      an_s2_q  <= an_s1_q;
      seg_s1_q <= seg_in;
      seg_s2_q <= seg_s1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      pat_q    <= pat_d;
      commit_q <= commit_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      bad_q    <= bad_d;
      mask_q   <= mask_d;
      frame_q  <= frame_d;
      err_q    <= err_d;
    end
  end

  assign digit_code      = code_q;
  assign digit_valid     = valid_q;
  assign digit_bad       = bad_q;
  assign frame_done      = frame_q;
  assign err_multi_anode = err_q;

endmodule

// File: doc/seg7_bus_monitor.md
Name: seg7_bus_monitor

Overview:
- Reader for the multiplexed 7-segment display bus driven by the clock display path: samples anode-select and segment lines.
- Reverse-decodes each stable segment pattern back to a 4-bit digit code and holds a per-digit shadow of what the display currently shows.
- Used on-chip for self-check/readback and in benches as a display scoreboard.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digit positions (anode lines), 1..8.
- STABLE_CYCLES, 4, consecutive identical synced samples required before a digit is committed, ≥1.
- ANODE_ACTIVE_LOW, 1, 1 = anode line low selects digit; 0 = high selects.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- an_in  in  NUM_DIGITS  anode selects, bit i = digit i, asynchronous to logic.
- seg_in  in  [0:6]  segment lines, active-low, seg_in[0]=a … seg_in[6]=g.
- digit_code  out  4*NUM_DIGITS  decoded code, digit i in bits [4i+3:4i].
- digit_valid  out  NUM_DIGITS  digit i committed at least once since reset.
- digit_bad  out  NUM_DIGITS  last committed pattern of digit i was unrecognised.
- frame_done  out  1  one-cycle pulse when every digit has committed since the last pulse.
- err_multi_anode  out  1  sticky: more than one anode seen active simultaneously.

Behaviour:
- Reset values: digit_code all 4'hF, digit_valid 0, digit_bad 0, frame_done 0, err_multi_anode 0, sync stages cleared to "no anode / blank" (7'b1111111), stability counter 0, frame mask 0.
- Input conditioning: an_in and seg_in each pass through two flops. Anodes are normalised to active-high internally per ANODE_ACTIVE_LOW.
- Decode table, segment pattern abcdefg → code:
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4
  - 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9
  - 1111110→4'hA (minus), 1111111→4'hF (blank)
  - any other pattern → 4'hE with digit_bad set
- Selection:
  - Exactly one normalised anode active → index idx valid.
  - Zero active → no selection.
  - More than one active → err_multi_anode set (held until rst); treated as no selection.
- Stability FSM, states IDLE, DWELL, HELD:
  - IDLE: no valid selection; counter 0. A valid selection moves to DWELL with counter 1 and latches (idx, pattern).
  - DWELL: each cycle with the same (idx, pattern) increments the counter. When the counter reaches STABLE_CYCLES, commit on that edge and move to HELD. Any change in (idx, pattern) restarts DWELL with counter 1 on the new value. Loss of selection → IDLE.
  - HELD: no further commits while (idx, pattern) is unchanged. A change restarts DWELL; loss of selection → IDLE. At most one commit per dwell.
- Commit: digit_code[idx] ← code, digit_valid[idx] ← 1, digit_bad[idx] ← (pattern unrecognised), frame mask bit idx ← 1.
- Latency: with STABLE_CYCLES=N, inputs stable from sampling edge E are visible on digit_code after edge E+N+2.
- frame_done:
  - Pulses for one cycle on the edge after the frame mask becomes all-ones; the mask clears on that same edge.
  - A commit arriving on the clear edge is kept in the new mask.
- Partially formed patterns at anode transitions (ghosting) shorter than STABLE_CYCLES are never committed.
- rst mid-dwell: returns to IDLE with all outputs at reset values; nothing is committed.

Test Plan:
- Reset, then hold an_in=8'b11111110, seg_in=7'b0010010 for 10 cycles (N=4) → digit_code[3:0]=4'h2 exactly 6 edges after first sample, digit_valid=8'h01, digit_bad=0.
- Scan digits 0..7 with codes 1,2,3,4,5,6,7,8, each for 8 cycles → digit_code=32'h87654321, digit_valid=8'hFF, a single frame_done pulse after digit 7 commits.
- Digit 2 pattern 1111110 then digit 3 pattern 0110110, each for 8 cycles → digit 2 code 4'hA, digit_bad[2]=0; digit 3 code 4'hE, digit_bad[3]=1.
- Digit 0 shows 0001111 for only 3 cycles (N=4), then changes → no commit; digit_code[3:0] remains 4'hF, digit_valid[0]=0.
- an_in=8'b11111100 for 2 cycles → err_multi_anode=1 and stays 1 across later valid scans; no commit occurs during the overlap.
- Assert rst during the 3rd cycle of a dwell → all outputs return to reset values; the following full dwell commits normally.
